// File: rtl/drive_arbiter.sv
// drive_arbiter: round-robin owner sequencer for a shared multi-driven net, with turnaround gaps between owners.
// Optional per-ownership hold limit with forced release is compiled in by defining DRIVE_ARBITER_HOLD_LIMIT_EN.
module drive_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     preempt
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_rot;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    w_win;
  logic [2:0]       r_turn;
  logic             r_busy;
  logic             r_preempt;
  logic             w_found;
  logic             w_own_req;
  logic             w_force;
  if (N_REQ < 2 || N_REQ > 16 || TURN_CYCLES < 1 || TURN_CYCLES > 7 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("drive_arbiter: parameter out of legal range");
  end
`ifdef DRIVE_ARBITER_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_CAP = 8'(MAX_HOLD);
  logic [7:0] r_hold;
  assign w_force = r_hold == HOLD_CAP;
`else
  assign w_force = 1'b0;
`endif
  // requests rotated so bit 0 is the requester at ptr; the lowest set bit wins
  assign w_rot = N_REQ'({req, req} >> r_ptr);
  // gnt is one-hot on the owner while in OWN, so this is req[owner]
  assign w_own_req = |(req & r_gnt);
  // round-robin search from ptr, ascending with wrap
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_ptr) + i) % N_REQ);
      end
  end
  // ownership FSM: grant, hold, release into turnaround, re-arbitrate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_turn    <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
`ifdef DRIVE_ARBITER_HOLD_LIMIT_EN
      r_hold    <= '0;
`endif
    end else begin
      r_preempt <= 1'b0;
      if (r_state == OWN) begin
        if (!w_own_req || w_force) begin
          r_state   <= TURN;
          r_gnt     <= '0;
          r_turn    <= 3'd1;
          r_preempt <= w_own_req;
        end
`ifdef DRIVE_ARBITER_HOLD_LIMIT_EN
        else if (r_hold != HOLD_CAP) r_hold <= r_hold + 8'd1;
`endif
      end else if (r_state == IDLE || r_turn == 3'(TURN_CYCLES)) begin
        if (w_found) begin
          r_state <= OWN;
          r_gnt   <= N_REQ'(1) << w_win;
          r_owner <= w_win;
          r_ptr   <= (w_win == IW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
          r_busy  <= 1'b1;
`ifdef DRIVE_ARBITER_HOLD_LIMIT_EN
          r_hold  <= 8'd1;
`endif
        end else begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else r_turn <= r_turn + 3'd1;
    end
  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign preempt = r_preempt;
endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: directed checks of reset, grant/release timing, rotation or hold, async reset and turnaround.
module tb_drive_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req0 = 4'b1111;
  logic [3:0] req1 = 4'b1111;
  logic [3:0] gnt0, gnt1;
  logic [1:0] own0, own1;
  logic       busy0, busy1, pre0, pre1;
  int         errs = 0;
  int         checks = 0;
  always #5 clk = ~clk;
  drive_arbiter u0 (
    .clk(clk), .rst(rst), .req(req0), .gnt(gnt0), .owner(own0), .busy(busy0), .preempt(pre0)
  );
  drive_arbiter #(.TURN_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .owner(own1), .busy(busy1), .preempt(pre1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] e;
    step(2);
    check("rst_gnt", gnt0, 0);
    check("rst_busy", busy0, 0);
    check("rst_owner", own0, 0);
    check("rst_pre", pre0, 0);
    check("rst_gnt1", gnt1, 0);
    rst = 1'b0;
    req0 = 4'b0000;
    req1 = 4'b0000;
    step();
    check("idle_gnt", gnt0, 0);
    req0 = 4'b0100;
    step();
    check("single_gnt", gnt0, 4'b0100);
    check("single_owner", own0, 2);
    check("single_busy", busy0, 1);
    step(4);
    check("single_hold", gnt0, 4'b0100);
    req0 = 4'b0000;
    step();
    check("rel_gnt", gnt0, 0);
    check("rel_busy", busy0, 1);
    step();
    check("idle_busy", busy0, 0);
    check("idle_gnt2", gnt0, 0);
`ifdef DRIVE_ARBITER_HOLD_LIMIT_EN
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0 = 4'b1111;
    for (int c = 1; c <= 45; c++) begin
      step();
      e = ((c - 1) % 9 < 8) ? 4'(1 << (((c - 1) / 9) % 4)) : 4'b0000;
      check("rot_gnt", gnt0, e);
      check("rot_pre", pre0, ((c - 1) % 9 == 8) ? 1 : 0);
      check("rot_onehot", ($countones(gnt0) <= 1) ? 1 : 0, 1);
    end
`else
    req0 = 4'b0010;
    step();
    check("hold_owner", own0, 1);
    check("hold_gnt", gnt0, 4'b0010);
    for (int c = 0; c < 99; c++) begin
      step();
      check("hold_gnt", gnt0, 4'b0010);
      check("hold_pre", pre0, 0);
    end
`endif
    req0 = 4'b0000;
    step(2);
    check("drain_busy", busy0, 0);
    req0 = 4'b1000;
    step();
    check("own3_gnt", gnt0, 4'b1000);
    check("own3_owner", own0, 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt", gnt0, 0);
    check("arst_busy", busy0, 0);
    check("arst_owner", own0, 0);
    rst = 1'b0;
    req0 = 4'b1010;
    step();
    check("post_rst_gnt", gnt0, 4'b0010);
    check("post_rst_owner", own0, 1);
    req0 = 4'b0000;
    req1 = 4'b0001;
    step();
    check("t3_gnt0", gnt1, 4'b0001);
    req1 = 4'b0010;
    step();
    check("t3_gap1", gnt1, 0);
    check("t3_busy", busy1, 1);
    step();
    check("t3_gap2", gnt1, 0);
    step();
    check("t3_gap3", gnt1, 0);
    step();
    check("t3_gnt1", gnt1, 4'b0010);
    check("t3_owner", own1, 1);
    check("t3_pre", pre1, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/drive_arbiter.md
# drive_arbiter

Round-robin sequencer that shares one multi-driven net bundle (triand/wire bus driven by several gate or assign sources) between `N_REQ` requesters. It grants at most one driver at a time and inserts a turnaround gap between owners, so two sources never drive the shared net in the same cycle. Optionally, it caps the number of cycles one owner may hold the net. It sits between the requesting source modules and the per-driver enables of the shared net.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `TURN_CYCLES`, default 1: idle gap between owners; legal range 1..7.
- `MAX_HOLD`, default 8: maximum consecutive granted cycles per ownership; legal range 2..255; used only when the hold limit is compiled in.
- `clk`  input  1: sole clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `req`  input  `N_REQ`: level request per driver; held high for as long as the driver wants the net.
- `gnt`  output  `N_REQ`: one-hot drive enable; registered.
- `owner`  output  `$clog2(N_REQ)`: index of the current or last owner; registered.
- `busy`  output  1: high while in OWN or TURN.
- `preempt`  output  1: one-cycle pulse when an owner is forcibly released.

## Operation
- States:
  - IDLE: `gnt`=0.
  - OWN: `gnt[owner]`=1.
  - TURN: `gnt`=0, turnaround counter running.
- Arbitration is evaluated at a clock edge in IDLE, or at the edge that ends the last TURN cycle:
  - Search `req` starting at `ptr` and ascending, wrapping modulo `N_REQ`.
  - The first set bit becomes the winner. Then `owner`←winner, `gnt`←one-hot(winner), `ptr`←(winner+1) mod `N_REQ`, state←OWN, hold count←1.
  - If no bit is set, the state becomes or stays IDLE.
- OWN:
  - If `req[owner]` is sampled low at an edge, then `gnt`←0, state←TURN, turn count←1.
  - Otherwise the hold count increments, saturating at `MAX_HOLD`.
  - Requests from non-owners are ignored during OWN.
- TURN: lasts exactly `TURN_CYCLES` cycles with `gnt`=0, then arbitration is evaluated as described above.
- Hold limit (only when compiled in):
  - In OWN, at the edge where the hold count equals `MAX_HOLD` and `req[owner]` is still high, the owner is released exactly as if it had dropped its request, and `preempt` pulses high for the following cycle.
  - `ptr` has already advanced past the owner, so other requesters win first. A sole requester is re-granted after the turnaround.
- Invariant: `$countones(gnt)` ≤ 1 in every cycle, and `gnt` is 0 for at least `TURN_CYCLES` cycles between two different grants, including a re-grant to the same index.
- A request that drops in IDLE before being sampled is never granted. There is no request latching.
- Reset values: state IDLE, `gnt`=0, `owner`=0, `busy`=0, `preempt`=0, `ptr`=0, all counters 0.
- Reset mid-operation: `gnt` and `busy` clear asynchronously on `rst` rise, with no clock edge required. After `rst` falls, the first arbitration starts from index 0.

## Timing
- Grant latency:
  - `req` high before edge k in IDLE gives `gnt` high in the cycle after edge k (1 cycle).
  - Minimum gap from release to the next grant is `TURN_CYCLES`+1 cycles after the owner's `req` falls.
- Release: `req[owner]` low sampled at edge k gives `gnt`=0 from edge k. An owner holds a minimum of 1 cycle.
- `busy` rises and falls at the same edges as the OWN/TURN entry and exit. `preempt` is high for exactly one cycle, coincident with the first TURN cycle.
- Simultaneous events:
  - The owner drops while another raises in the same cycle: TURN follows, then the new requester is granted.
  - Forced release and request drop at the same edge: this counts as a normal release, and `preempt` stays 0.

## Configuration
- `DRIVE_ARBITER_HOLD_LIMIT_EN` defined: the hold counter and forced release are active, and `preempt` operates as described.
- `DRIVE_ARBITER_HOLD_LIMIT_EN` undefined: there is no hold counter, an owner keeps the net until it drops `req`, `preempt` is tied to 0, and `MAX_HOLD` is ignored.

## Test plan
- Reset: assert `rst` with `req`=4'b1111 → `gnt`=0, `busy`=0, `owner`=0, `preempt`=0 throughout.
- Single requester (defaults):
  - `req`=4'b0100 at cycle 0 → `gnt`=4'b0100 from cycle 1, `owner`=2.
  - `req` drops at cycle 5 → `gnt`=0 at cycle 6, `busy`=1 in cycle 6, `busy`=0 in cycle 7.
- Rotation with the macro on, `MAX_HOLD`=8, `TURN_CYCLES`=1, `req`=4'b1111 held:
  - Owners run 0,1,2,3,0, each granted 8 cycles then 1 gap cycle, so a new grant starts every 9 cycles.
  - `preempt` pulses once per gap, and `gnt` is never multi-hot.
- Macro off: `req`=4'b0010 held 100 cycles → `gnt`=4'b0010 for all 100 cycles, `preempt` never 1.
- Async reset in OWN (owner 3): `rst` pulsed between edges → `gnt`=0 before the next edge. With `req`=4'b1010 after reset, `owner`=1 is granted first.
- Handover with `TURN_CYCLES`=3: owner 0 drops while `req[1]` rises in the same cycle → `gnt`=0 for exactly 3 cycles, then 4'b0010.
